// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round controller: initial AddRoundKey, then NR rounds through an external datapath.
// Optional macro AES_ROUND_PIPE_EN: datapath output is registered, so each round spends a ROUND and a WAIT cycle.
module aes_round_sequencer #(
    parameter int NR    = 10,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     data_out,
    output logic             busy,
    output logic [IDX_W-1:0] key_idx,
    input  logic [127:0]     key_word,
    output logic [127:0]     rnd_state,
    output logic [127:0]     rnd_key,
    output logic             rnd_last,
    input  logic [127:0]     rnd_out
);

`ifdef AES_ROUND_PIPE_EN
    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE, S_WAIT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;
`endif

    localparam logic [IDX_W-1:0] LAST_RND = IDX_W'(NR);

    state_t           state_q, state_d;
    logic [127:0]     st_q, st_d;
    logic [IDX_W-1:0] rnd_q, rnd_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            st_q    <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rnd_d   = rnd_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    st_d    = data_in ^ key_word;
                    rnd_d   = {{(IDX_W-1){1'b0}}, 1'b1};
                    state_d = S_ROUND;
                end
            end
`ifdef AES_ROUND_PIPE_EN
            // Inputs are held through ROUND; the registered result is taken in WAIT.
            S_ROUND: state_d = S_WAIT;
            S_WAIT: begin
                st_d = rnd_out;
                if (rnd_q == LAST_RND) begin
                    state_d = S_DONE;
                end else begin
                    rnd_d   = rnd_q + 1'b1;
                    state_d = S_ROUND;
                end
            end
`else
            S_ROUND: begin
                st_d = rnd_out;
                if (rnd_q == LAST_RND) begin
                    state_d = S_DONE;
                end else begin
                    rnd_d = rnd_q + 1'b1;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    rnd_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) && !rst;
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        data_out  = st_q;
        rnd_state = st_q;
        rnd_key   = key_word;
        key_idx   = '0;
        rnd_last  = 1'b0;
`ifdef AES_ROUND_PIPE_EN
        if (state_q == S_ROUND || state_q == S_WAIT) begin
`else
        if (state_q == S_ROUND) begin
`endif
            key_idx  = rnd_q;
            rnd_last = (rnd_q == LAST_RND);
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: models the key store and round datapath around FIPS-197 vectors.
module tb_aes_round_sequencer;

    localparam int NR    = 10;
    localparam int IDX_W = 4;
`ifdef AES_ROUND_PIPE_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int LAT = NR * STEP;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, out_valid, out_ready, busy, rnd_last;
    logic [127:0]     data_in, data_out, key_word, rnd_state, rnd_key, rnd_out;
    logic [IDX_W-1:0] key_idx;

    logic [7:0]   sb [256];
    logic [127:0] rk [2][16];
    logic         key_set;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_round_sequencer #(.NR(NR), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .busy(busy), .key_idx(key_idx), .key_word(key_word),
        .rnd_state(rnd_state), .rnd_key(rnd_key), .rnd_last(rnd_last), .rnd_out(rnd_out)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        end
        return inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0] b [16];
        logic [7:0] r [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) b[i] = sb[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++) r[4*c+rw] = b[4*((c+rw)%4)+rw];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = r[4*c]; a1 = r[4*c+1]; a2 = r[4*c+2]; a3 = r[4*c+3];
                r[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                r[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                r[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                r[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = r[i];
        return res ^ k;
    endfunction

    task automatic expand_key(input logic [127:0] key, input int set);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]] ^ rc, sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 16; k++)
            rk[set][k] = (k <= NR) ? {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]} : 128'h0;
    endtask

    assign key_word = rk[key_set][key_idx];

`ifdef AES_ROUND_PIPE_EN
    always @(posedge clk) rnd_out <= aes_round(rnd_state, rnd_key, rnd_last);
`else
    always_comb rnd_out = aes_round(rnd_state, rnd_key, rnd_last);
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during got=%b exp=0", in_ready); end
        tick(); tick();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || rnd_last !== 1'b0) begin
            errors++; $display("FAIL reset_flags got ov=%b busy=%b last=%b exp=0", out_valid, busy, rnd_last); end
        checks++; if (data_out !== 128'h0 || rnd_state !== 128'h0 || key_idx !== 4'h0) begin
            errors++; $display("FAIL reset_values got data_out=%h rnd_state=%h key_idx=%0d exp=0", data_out, rnd_state, key_idx); end
        rst = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after got=%b exp=1", in_ready); end
        $display("reset: done");
    endtask

    task automatic test_fips_c1();
        int cyc;
        logic [IDX_W-1:0] exp_idx;
        data_in = C1_PT; in_valid = 1'b1;
        checks++; if (in_ready !== 1'b1 || key_idx !== 4'd0) begin
            errors++; $display("FAIL c1_accept got in_ready=%b key_idx=%0d exp 1/0", in_ready, key_idx); end
        tick();
        in_valid = 1'b0; data_in = '0;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            exp_idx = IDX_W'(cyc / STEP + 1);
            checks++; if (key_idx !== exp_idx || rnd_last !== (exp_idx == IDX_W'(NR))) begin
                errors++; $display("FAIL key_trace cyc=%0d got idx=%0d last=%b exp idx=%0d last=%b",
                                   cyc, key_idx, rnd_last, exp_idx, exp_idx == IDX_W'(NR)); end
            tick(); cyc++;
        end
        checks++; if (cyc != LAT) begin errors++; $display("FAIL c1_latency got=%0d exp=%0d", cyc, LAT); end
        checks++; if (data_out !== C1_CT) begin errors++; $display("FAIL c1_ciphertext got=%h exp=%h", data_out, C1_CT); end
        checks++; if (key_idx !== 4'd0 || rnd_last !== 1'b0) begin
            errors++; $display("FAIL c1_done_idx got idx=%0d last=%b exp 0/0", key_idx, rnd_last); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL c1_handshake got ov=%b ir=%b exp 0/1", out_valid, in_ready); end
        $display("fips_c1: ct=%h latency=%0d", data_out, cyc);
    endtask

    task automatic test_backpressure();
        int cyc;
        data_in = C1_PT; in_valid = 1'b1; tick(); in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 200) begin tick(); cyc++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout got ov=%b exp=1", out_valid); end
        in_valid = 1'b1; data_in = B_PT;
        for (int i = 0; i < 7; i++) begin
            checks++; if (out_valid !== 1'b1 || data_out !== C1_CT || in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL bp_hold i=%0d got ov=%b ir=%b busy=%b data=%h exp 1/0/1 %h",
                                   i, out_valid, in_ready, busy, data_out, C1_CT); end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_release got ov=%b ir=%b busy=%b exp 0/1/0", out_valid, in_ready, busy); end
        $display("backpressure: held 7 cycles, released");
    endtask

    task automatic test_back_to_back();
        int  cnt;
        bit  got_a, accepted;
        key_set = 1'b0; data_in = C1_PT; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        data_in = B_PT;
        cnt = 0; got_a = 0; accepted = 0;
        while (!accepted && cnt < 200) begin
            tick(); cnt++;
            if (out_valid) begin
                checks++; if (data_out !== C1_CT) begin errors++; $display("FAIL b2b_first got=%h exp=%h", data_out, C1_CT); end
                got_a = 1; key_set = 1'b1;
            end
            if (in_ready) begin tick(); cnt++; accepted = 1; end
        end
        in_valid = 1'b0;
        checks++; if (!got_a || cnt != LAT + 2) begin
            errors++; $display("FAIL b2b_spacing got=%0d seen_first=%0d exp=%0d", cnt, got_a, LAT + 2); end
        cnt = 0;
        while (!out_valid && cnt < 200) begin tick(); cnt++; end
        checks++; if (data_out !== B_CT || out_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_second got=%h ov=%b exp=%h", data_out, out_valid, B_CT); end
        tick(); out_ready = 1'b0; key_set = 1'b0;
        $display("back_to_back: second ct=%h", data_out);
    endtask

    task automatic test_mid_reset();
        int cyc;
        data_in = C1_PT; in_valid = 1'b1; tick(); in_valid = 1'b0;
        cyc = 0;
        while (key_idx != 4'd5 && cyc < 50) begin tick(); cyc++; end
        checks++; if (key_idx !== 4'd5) begin errors++; $display("FAIL mr_reach5 got=%0d exp=5", key_idx); end
        #2 rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || key_idx !== 4'd0 || rnd_last !== 1'b0) begin
            errors++; $display("FAIL mr_flags got ir=%b ov=%b busy=%b idx=%0d last=%b exp 0", in_ready, out_valid, busy, key_idx, rnd_last); end
        checks++; if (data_out !== 128'h0 || rnd_state !== 128'h0) begin
            errors++; $display("FAIL mr_data got data=%h state=%h exp 0", data_out, rnd_state); end
        tick(); rst = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL mr_no_output i=%0d got ov=%b busy=%b exp 0/0", i, out_valid, busy); end
            tick();
        end
        data_in = C1_PT; in_valid = 1'b1; tick(); in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 200) begin tick(); cyc++; end
        checks++; if (data_out !== C1_CT || cyc != LAT) begin
            errors++; $display("FAIL mr_recover got=%h lat=%0d exp=%h lat=%0d", data_out, cyc, C1_CT, LAT); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        $display("mid_reset: recovered ct=%h", data_out);
    endtask

    task automatic test_valid_while_busy();
        int cyc;
        data_in = C1_PT; in_valid = 1'b1; tick(); in_valid = 1'b0;
        cyc = 0;
        while (key_idx != 4'd3 && cyc < 50) begin tick(); cyc++; end
        in_valid = 1'b1; data_in = B_PT;
        checks++; if (in_ready !== 1'b0 || key_idx !== 4'd3) begin
            errors++; $display("FAIL vb_busy got ir=%b idx=%0d exp 0/3", in_ready, key_idx); end
        tick(); in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 200) begin tick(); cyc++; end
        checks++; if (data_out !== C1_CT) begin errors++; $display("FAIL vb_ciphertext got=%h exp=%h", data_out, C1_CT); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL vb_idle got busy=%b ir=%b exp 0/1", busy, in_ready); end
        $display("valid_while_busy: ct=%h", C1_CT);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = '0; key_set = 1'b0;
        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
        expand_key(C1_KEY, 0);
        expand_key(B_KEY, 1);
        test_reset();
        test_fips_c1();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_valid_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Iterative AES-128 encryption controller. It accepts one 128-bit plaintext block at a time and drives the shared combinational round datapath (SubBytes→ShiftRows→MixColumns→AddRoundKey, with a MixColumns bypass for the last round) through rounds 1..10. It fetches round keys from the key-expansion store by index and returns the ciphertext to the UART framing logic over a valid/ready handshake.

## Interface
Parameters:
- NR, 10, number of rounds after the initial AddRoundKey.
- IDX_W, 4, width of round/key index (must hold NR).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  plaintext present.
- in_ready  out  1  sequencer can accept a block.
- data_in  in  128  plaintext block.
- out_valid  out  1  ciphertext present.
- out_ready  in  1  consumer takes ciphertext.
- data_out  out  128  ciphertext (the state register).
- busy  out  1  a block is being processed (not IDLE).
- key_idx  out  IDX_W  round-key index requested from key store.
- key_word  in  128  round key for key_idx, valid combinationally in the same cycle.
- rnd_state  out  128  state fed to the round datapath.
- rnd_key  out  128  round key fed to the datapath (= key_word).
- rnd_last  out  1  final round: datapath skips MixColumns.
- rnd_out  in  128  datapath result, combinational from rnd_state/rnd_key/rnd_last.

## Operation
- State register `st` (128 b) and round counter `rnd` (IDX_W b).
- FSM states: IDLE, ROUND, DONE. With AES_ROUND_PIPE_EN, a fourth state, WAIT.
- IDLE: in_ready=1, key_idx=0. On in_valid&&in_ready: st ← data_in ^ key_word (initial AddRoundKey), rnd ← 1, go to ROUND.
- ROUND: key_idx=rnd, rnd_state=st, rnd_last=(rnd==NR). Each cycle: st ← rnd_out. If rnd==NR, go to DONE. Otherwise rnd ← rnd+1.
- DONE: out_valid=1, data_out=st, held stable until out_ready. On out_valid&&out_ready, go to IDLE and clear rnd to 0.
- in_ready is asserted only in IDLE; no new block is accepted in the cycle DONE is left.
- in_valid is ignored outside IDLE; data_in is sampled only at acceptance.
- key_idx is 0 in IDLE and DONE. rnd_key always equals key_word.
- Reset, including mid-operation: FSM→IDLE, st←0, rnd←0. The block in flight is discarded with no output.
- Reset values: in_ready=1 after reset deasserts (0 while rst high), out_valid=0, busy=0, data_out=0, key_idx=0, rnd_state=0, rnd_last=0.

## Timing
- Acceptance at clock edge N.
- Default build: one round per cycle. Round r is evaluated in the cycle after edge N+r−1 and captured at edge N+r. out_valid rises after edge N+NR (10 cycles latency).
- out_valid stays high until the out_ready handshake edge. It drops the next cycle, and in_ready rises in that same cycle.
- Minimum accept-to-accept spacing: NR+2 cycles with out_ready tied high.
- rnd_last is high only during the round-NR cycle.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Configuration
- AES_ROUND_PIPE_EN:
  - Defined: rnd_out is registered. Each round takes two cycles: ROUND presents rnd_state/key_idx, then WAIT captures st from the registered rnd_out. rnd_state, key_idx and rnd_last are held constant across both cycles. Latency becomes 2·NR (20 cycles).
  - Undefined: single-cycle rounds as above, and there is no WAIT state.

## Test plan
- FIPS-197 C.1: key store loaded with the expansion of 000102…0f, data_in=00112233445566778899aabbccddeeff → data_out=69c4e0d86a7b0430d8cdb78070b4c55a; out_valid 10 cycles after acceptance (20 with AES_ROUND_PIPE_EN).
- Backpressure: hold out_ready=0 for 7 cycles after out_valid → data_out stable, in_ready=0, busy=1. Raise out_ready → one handshake, then in_ready=1 the next cycle.
- Back-to-back blocks: two vectors, in_valid held high, out_ready=1 → both ciphertexts correct; the second acceptance occurs exactly NR+2 cycles after the first.
- Key-index trace: monitor key_idx during a block → sequence 0 at accept, then 1,2,…,10; rnd_last=1 only when key_idx=10.
- Mid-operation reset: assert rst asynchronously at round 5 → all outputs immediately reach reset values, no out_valid. The next block encrypts correctly.
- in_valid while busy: pulse in_valid with different data at round 3 → ignored, and the original ciphertext is unchanged.
